// File: rtl/reg_file_2r1w.sv
// Purpose: DEPTH x DATA_W register file, one byte-enabled write port, two independent read ports.
// Latency: reads return one clock after the request, with optional same-edge write bypass.
// Backpressure: none; every request is accepted each cycle and out-of-range accesses set sticky err.
module reg_file_2r1w #(
    parameter int                DATA_W  = 32,
    parameter int                DEPTH   = 16,
    parameter int                BYPASS  = 1,
    parameter logic [DATA_W-1:0] RST_VAL = '0,
    localparam int               ADDR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int               BE_W    = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [BE_W-1:0]   wr_be,
    input  logic [DATA_W-1:0] din,
    input  logic              rd_en_a,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [DATA_W-1:0] dout_a,
    output logic              vld_a,
    input  logic              rd_en_b,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] dout_b,
    output logic              vld_b,
    output logic              err
);

    localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];

    logic [DATA_W-1:0] mem [DEPTH];
    logic              wr_ok;
    logic              wr_do;
    logic [ADDR_W-1:0] rd_addr [2];
    logic              rd_ok   [2];
    logic [DATA_W-1:0] rd_data [2];

    assign rd_addr[0] = rd_addr_a;
    assign rd_addr[1] = rd_addr_b;
    assign wr_ok      = ({1'b0, wr_addr} < DEPTH_C);
    // clear wins over a same-edge write, which also disables forwarding
    assign wr_do      = wr_en && wr_ok && !clr;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_ok[p]   = ({1'b0, rd_addr[p]} < DEPTH_C);
            rd_data[p] = '0;
            if (rd_ok[p]) begin
                rd_data[p] = mem[rd_addr[p]];
                if ((BYPASS != 0) && wr_do && (wr_addr == rd_addr[p])) begin
                    for (int i = 0; i < BE_W; i++) begin
                        if (wr_be[i]) begin
                            rd_data[p][8*i +: 8] = din[8*i +: 8];
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int w = 0; w < DEPTH; w++) begin
                mem[w] <= RST_VAL;
            end
        end else if (clr) begin
            for (int w = 0; w < DEPTH; w++) begin
                mem[w] <= RST_VAL;
            end
        end else if (wr_do) begin
            for (int i = 0; i < BE_W; i++) begin
                if (wr_be[i]) begin
                    mem[wr_addr][8*i +: 8] <= din[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (clr) begin
            err <= 1'b0;
        end else if ((wr_en && !wr_ok) || (rd_en_a && !rd_ok[0]) || (rd_en_b && !rd_ok[1])) begin
            err <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_a <= '0;
            vld_a  <= 1'b0;
            dout_b <= '0;
            vld_b  <= 1'b0;
        end else begin
            vld_a <= rd_en_a;
            vld_b <= rd_en_b;
            if (rd_en_a) begin
                dout_a <= rd_data[0];
            end
            if (rd_en_b) begin
                dout_b <= rd_data[1];
            end
        end
    end

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Three instances: bypass/DEPTH16, no-bypass/DEPTH16, bypass/DEPTH12 with nonzero reset value.
// Reads push expected words into per-port queues; a negedge monitor pops and compares on vld.
module tb_reg_file_2r1w;

    typedef struct packed {
        logic [1:0]  d;
        logic [31:0] v;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr       [3];
    logic        wr_en     [3];
    logic [3:0]  wr_addr   [3];
    logic [3:0]  wr_be     [3];
    logic [31:0] din       [3];
    logic        rd_en_a   [3];
    logic [3:0]  rd_addr_a [3];
    logic [31:0] dout_a    [3];
    logic        vld_a     [3];
    logic        rd_en_b   [3];
    logic [3:0]  rd_addr_b [3];
    logic [31:0] dout_b    [3];
    logic        vld_b     [3];
    logic        err       [3];

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea;
    exp_t eb;
    int   checks = 0;
    int   errors = 0;

    always #50 clk = ~clk;

    reg_file_2r1w #(.DATA_W(32), .DEPTH(16), .BYPASS(1), .RST_VAL(32'h0)) u_byp (
        .clk(clk), .rst(rst), .clr(clr[0]), .wr_en(wr_en[0]), .wr_addr(wr_addr[0]),
        .wr_be(wr_be[0]), .din(din[0]), .rd_en_a(rd_en_a[0]), .rd_addr_a(rd_addr_a[0]),
        .dout_a(dout_a[0]), .vld_a(vld_a[0]), .rd_en_b(rd_en_b[0]), .rd_addr_b(rd_addr_b[0]),
        .dout_b(dout_b[0]), .vld_b(vld_b[0]), .err(err[0]));

    reg_file_2r1w #(.DATA_W(32), .DEPTH(16), .BYPASS(0), .RST_VAL(32'h0)) u_nobyp (
        .clk(clk), .rst(rst), .clr(clr[1]), .wr_en(wr_en[1]), .wr_addr(wr_addr[1]),
        .wr_be(wr_be[1]), .din(din[1]), .rd_en_a(rd_en_a[1]), .rd_addr_a(rd_addr_a[1]),
        .dout_a(dout_a[1]), .vld_a(vld_a[1]), .rd_en_b(rd_en_b[1]), .rd_addr_b(rd_addr_b[1]),
        .dout_b(dout_b[1]), .vld_b(vld_b[1]), .err(err[1]));

    reg_file_2r1w #(.DATA_W(32), .DEPTH(12), .BYPASS(1), .RST_VAL(32'h0000_5A5A)) u_d12 (
        .clk(clk), .rst(rst), .clr(clr[2]), .wr_en(wr_en[2]), .wr_addr(wr_addr[2]),
        .wr_be(wr_be[2]), .din(din[2]), .rd_en_a(rd_en_a[2]), .rd_addr_a(rd_addr_a[2]),
        .dout_a(dout_a[2]), .vld_a(vld_a[2]), .rd_en_b(rd_en_b[2]), .rd_addr_b(rd_addr_b[2]),
        .dout_b(dout_b[2]), .vld_b(vld_b[2]), .err(err[2]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        for (int d = 0; d < 3; d++) begin
            clr[d]     = 1'b0;
            wr_en[d]   = 1'b0;
            wr_be[d]   = 4'h0;
            rd_en_a[d] = 1'b0;
            rd_en_b[d] = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #10;
        idle();
    endtask

    task automatic wr(input int d, input logic [3:0] a, input logic [3:0] be, input logic [31:0] v);
        wr_en[d]   = 1'b1;
        wr_addr[d] = a;
        wr_be[d]   = be;
        din[d]     = v;
    endtask

    task automatic rda(input int d, input logic [3:0] a, input logic [31:0] e);
        exp_t x;
        x.d = d[1:0];
        x.v = e;
        rd_en_a[d]   = 1'b1;
        rd_addr_a[d] = a;
        qa.push_back(x);
    endtask

    task automatic rdb(input int d, input logic [3:0] a, input logic [31:0] e);
        exp_t x;
        x.d = d[1:0];
        x.v = e;
        rd_en_b[d]   = 1'b1;
        rd_addr_b[d] = a;
        qb.push_back(x);
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (vld_a[d]) begin
                if (qa.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_vld_a dut%0d: got data %h, expected no read", d, dout_a[d]);
                end else begin
                    ea = qa.pop_front();
                    chk($sformatf("port_a_dut%0d_index", d), 32'(d), 32'(ea.d));
                    chk($sformatf("port_a_dut%0d_data", d), dout_a[d], ea.v);
                end
            end
            if (vld_b[d]) begin
                if (qb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_vld_b dut%0d: got data %h, expected no read", d, dout_b[d]);
                end else begin
                    eb = qb.pop_front();
                    chk($sformatf("port_b_dut%0d_index", d), 32'(d), 32'(eb.d));
                    chk($sformatf("port_b_dut%0d_data", d), dout_b[d], eb.v);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        idle();
        for (int d = 0; d < 3; d++) begin
            wr_addr[d]   = 4'h0;
            din[d]       = 32'h0;
            rd_addr_a[d] = 4'd5;
            rd_addr_b[d] = 4'h0;
            rd_en_a[d]   = 1'b1;
        end

        // reads requested while reset is held must produce nothing
        #200;
        chk("rst_dout_a", dout_a[0], 32'h0);
        chk("rst_vld_a", 32'(vld_a[0]), 32'h0);
        chk("rst_err", 32'(err[0]), 32'h0);
        chk("rst_dout_a_d12", dout_a[2], 32'h0);
        #20;
        rst = 1'b0;
        rda(0, 4'd5, 32'h0);
        rda(1, 4'd5, 32'h0);
        rda(2, 4'd5, 32'h0000_5A5A);
        tick();

        // full write, partial write, same-edge bypass
        wr(0, 4'd3, 4'hF, 32'hDEAD_BEEF); tick();
        rda(0, 4'd3, 32'hDEAD_BEEF); tick();
        wr(0, 4'd3, 4'b0101, 32'h1122_3344); tick();
        rdb(0, 4'd3, 32'hDE22_BE44); tick();
        wr(0, 4'd7, 4'hF, 32'hCAFE_F00D);
        rda(0, 4'd7, 32'hCAFE_F00D);
        rdb(0, 4'd7, 32'hCAFE_F00D); tick();
        wr(0, 4'd3, 4'b1000, 32'h9900_0000);
        rda(0, 4'd3, 32'h9922_BE44); tick();
        wr(0, 4'd3, 4'h0, 32'hFFFF_FFFF);
        rdb(0, 4'd7, 32'hCAFE_F00D); tick();
        rda(0, 4'd3, 32'h9922_BE44); tick();
        tick();
        chk("hold_dout_a", dout_a[0], 32'h9922_BE44);
        chk("hold_vld_a", 32'(vld_a[0]), 32'h0);

        // clear: same-edge read sees old data, same-edge write is dropped
        clr[0] = 1'b1;
        wr(0, 4'd5, 4'hF, 32'h7777_7777);
        rda(0, 4'd3, 32'h9922_BE44); tick();
        rda(0, 4'd3, 32'h0);
        rdb(0, 4'd5, 32'h0); tick();
        chk("err_in_range_only", 32'(err[0]), 32'h0);

        // no bypass: same-edge read returns pre-write word
        wr(1, 4'd7, 4'hF, 32'h1234_5678); tick();
        wr(1, 4'd7, 4'b0011, 32'hCAFE_F00D);
        rda(1, 4'd7, 32'h1234_5678);
        rdb(1, 4'd7, 32'h1234_5678); tick();
        rda(1, 4'd7, 32'h1234_F00D); tick();

        // DEPTH=12: out-of-range write and read, clear
        wr(2, 4'd13, 4'hF, 32'hFFFF_FFFF); tick();
        chk("err_oor_write", 32'(err[2]), 32'h1);
        rda(2, 4'd1, 32'h0000_5A5A);
        rdb(2, 4'd5, 32'h0000_5A5A); tick();
        wr(2, 4'd11, 4'hF, 32'h0BAD_F00D); tick();
        rda(2, 4'd11, 32'h0BAD_F00D); tick();
        clr[2] = 1'b1; tick();
        chk("err_cleared", 32'(err[2]), 32'h0);
        rda(2, 4'd14, 32'h0); tick();
        chk("err_oor_read", 32'(err[2]), 32'h1);
        clr[2] = 1'b1;
        wr(2, 4'd12, 4'hF, 32'h0000_0001); tick();
        chk("clr_beats_err", 32'(err[2]), 32'h0);
        rda(2, 4'd11, 32'h0000_5A5A);
        rdb(2, 4'd0, 32'h0000_5A5A); tick();

        // reset in the middle of back-to-back reads
        wr(2, 4'd4, 4'hF, 32'h4444_4444); tick();
        rda(2, 4'd15, 32'h0); tick();
        rd_en_a[2]   = 1'b1;
        rd_addr_a[2] = 4'd4;
        rd_en_b[2]   = 1'b1;
        rd_addr_b[2] = 4'd12;
        @(posedge clk);
        #20;
        chk("err_before_rst", 32'(err[2]), 32'h1);
        #10;
        rst = 1'b1;
        idle();
        #1;
        chk("midrst_dout_a", dout_a[2], 32'h0);
        chk("midrst_vld_a", 32'(vld_a[2]), 32'h0);
        chk("midrst_vld_b", 32'(vld_b[2]), 32'h0);
        chk("midrst_err", 32'(err[2]), 32'h0);
        #20;
        rst = 1'b0;
        @(posedge clk);
        #10;
        rda(2, 4'd4, 32'h0000_5A5A);
        rdb(2, 4'd7, 32'h0000_5A5A); tick();
        rda(0, 4'd7, 32'h0); tick();
        tick();

        chk("qa_drained", 32'(qa.size()), 32'h0);
        chk("qb_drained", 32'(qb.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
